// File: rtl/div_pkg.sv
// Shared definitions for the multi-cycle restoring divide sequencer:
// FSM state encoding, latency constants and the divide-by-zero quotient fill.
package div_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int DIV_DEFAULT_WIDTH = 32;
  // Request-cycle to result-cycle distance for a full iterative divide.
  localparam int DIV_LATENCY = DIV_DEFAULT_WIDTH + 1;

  // Every quotient bit takes this value on a divide by zero (all ones).
  localparam logic DIV0_QUO_BIT = 1'b1;

  function automatic int div_latency(input int width);
    return width + 1;
  endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration: shift {rem, quo} left,
// trial-subtract the divisor, keep or restore, and shift in the quotient bit.
module div_step #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] i_rem,
  input  logic [DATA_WIDTH-1:0] i_quo,
  input  logic [DATA_WIDTH-1:0] i_div,
  output logic [DATA_WIDTH-1:0] o_rem,
  output logic [DATA_WIDTH-1:0] o_quo
);

  // One spare bit: the shifted remainder can reach 2*divisor-1, which
  // overflows DATA_WIDTH when the divisor has its MSB set.
  logic [DATA_WIDTH:0] w_shift;
  logic [DATA_WIDTH:0] w_diff;

  assign w_shift = {i_rem, i_quo[DATA_WIDTH-1]};
  assign w_diff  = w_shift - {1'b0, i_div};

  always_comb begin
    o_rem = w_shift[DATA_WIDTH-1:0];
    o_quo = {i_quo[DATA_WIDTH-2:0], 1'b0};
    if (!w_diff[DATA_WIDTH]) begin
      o_rem = w_diff[DATA_WIDTH-1:0];
      o_quo = {i_quo[DATA_WIDTH-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/div_sequencer.sv
// Multi-cycle divide controller that stalls the core while a restoring divider
// iterates. Define SIGNED_DIV_EN to honour signed_i (abs value, overflow, sign fix-up).
module div_sequencer
  import div_pkg::*;
#(
  parameter int DATA_WIDTH = DIV_DEFAULT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic [DATA_WIDTH-1:0] dividend_i,
  input  logic [DATA_WIDTH-1:0] divisor_i,
  input  logic                  signed_i,
  output logic                  ready_o,
  output logic                  stall_o,
  output logic                  done_o,
  output logic [DATA_WIDTH-1:0] quotient_o,
  output logic [DATA_WIDTH-1:0] remainder_o
);

  localparam int                  CW       = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0]       LAST_CNT = CW'(DATA_WIDTH - 1);
  localparam logic [DATA_WIDTH-1:0] DIV0_QUO = {DATA_WIDTH{DIV0_QUO_BIT}};

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_rem;
  logic [DATA_WIDTH-1:0] r_quo;
  logic [DATA_WIDTH-1:0] r_div;
  logic [CW-1:0]         r_cnt;

  logic [DATA_WIDTH-1:0] w_step_rem;
  logic [DATA_WIDTH-1:0] w_step_quo;
  logic [DATA_WIDTH-1:0] w_a_mag;
  logic [DATA_WIDTH-1:0] w_b_mag;
  logic [DATA_WIDTH-1:0] w_quo_fin;
  logic [DATA_WIDTH-1:0] w_rem_fin;
  logic                  w_div_zero;
  logic                  w_ovf;
  logic                  w_accept;

  assign w_accept   = (r_state == S_IDLE) && start_i;
  assign w_div_zero = (divisor_i == '0);
  assign ready_o    = (r_state == S_IDLE);
  assign stall_o    = w_accept || (r_state == S_RUN);

`ifdef SIGNED_DIV_EN
  logic r_neg_q;
  logic r_neg_r;
  logic w_a_neg;
  logic w_b_neg;

  assign w_a_neg   = signed_i & dividend_i[DATA_WIDTH-1];
  assign w_b_neg   = signed_i & divisor_i[DATA_WIDTH-1];
  assign w_a_mag   = w_a_neg ? -dividend_i : dividend_i;
  assign w_b_mag   = w_b_neg ? -divisor_i  : divisor_i;
  assign w_ovf     = signed_i && (dividend_i == {1'b1, {(DATA_WIDTH-1){1'b0}}})
                     && (divisor_i == '1);
  assign w_quo_fin = r_neg_q ? -w_step_quo : w_step_quo;
  assign w_rem_fin = r_neg_r ? -w_step_rem : w_step_rem;

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_neg_q <= w_a_neg ^ w_b_neg;
      r_neg_r <= w_a_neg;
    end
  end
`else
  logic w_unused_signed;

  assign w_unused_signed = signed_i;
  assign w_a_mag         = dividend_i;
  assign w_b_mag         = divisor_i;
  assign w_ovf           = 1'b0;
  assign w_quo_fin       = w_step_quo;
  assign w_rem_fin       = w_step_rem;
`endif

  div_step #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_step (
    .i_rem(r_rem),
    .i_quo(r_quo),
    .i_div(r_div),
    .o_rem(w_step_rem),
    .o_quo(w_step_quo)
  );

  // Working registers carry no reset; they are always loaded on accept.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_rem <= '0;
      r_quo <= w_a_mag;
      r_div <= w_b_mag;
      r_cnt <= LAST_CNT;
    end else if (r_state == S_RUN) begin
      r_rem <= w_step_rem;
      r_quo <= w_step_quo;
      r_cnt <= r_cnt - 1'b1;
    end
  end

  // Results are written on the edge entering DONE so they are valid with done_o.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      done_o      <= 1'b0;
      quotient_o  <= '0;
      remainder_o <= '0;
    end else begin
      done_o <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            if (w_div_zero) begin
              quotient_o  <= DIV0_QUO;
              remainder_o <= dividend_i;
              done_o      <= 1'b1;
              r_state     <= S_DONE;
            end else if (w_ovf) begin
              quotient_o  <= dividend_i;
              remainder_o <= '0;
              done_o      <= 1'b1;
              r_state     <= S_DONE;
            end else begin
              r_state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (r_cnt == '0) begin
            quotient_o  <= w_quo_fin;
            remainder_o <= w_rem_fin;
            done_o      <= 1'b1;
            r_state     <= S_DONE;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_sequencer.sv
// Scoreboard bench for div_sequencer: randomized and directed divides checked
// against an arithmetic reference model; honours SIGNED_DIV_EN like the DUT.
module tb_div_sequencer;

  localparam int W        = 32;
  localparam int FULL_LAT = W + 1;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start_i = 1'b0;
  logic         signed_i = 1'b0;
  logic [W-1:0] dividend_i = '0;
  logic [W-1:0] divisor_i = '0;
  logic         ready_o;
  logic         stall_o;
  logic         done_o;
  logic [W-1:0] quotient_o;
  logic [W-1:0] remainder_o;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    int           due;
  } exp_t;

  exp_t sbq[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;

  div_sequencer #(.DATA_WIDTH(W)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start_i(start_i),
    .dividend_i(dividend_i),
    .divisor_i(divisor_i),
    .signed_i(signed_i),
    .ready_o(ready_o),
    .stall_o(stall_o),
    .done_o(done_o),
    .quotient_o(quotient_o),
    .remainder_o(remainder_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain integer division with the architectural corner cases.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                       output logic [W-1:0] q, output logic [W-1:0] r, output int lat);
    lat = FULL_LAT;
    if (b == 0) begin
      q = '1;
      r = a;
      lat = 1;
    end else begin
      q = a / b;
      r = a % b;
`ifdef SIGNED_DIV_EN
      if (s) begin
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          q = a;
          r = '0;
          lat = 1;
        end else begin
          q = $signed(a) / $signed(b);
          r = $signed(a) % $signed(b);
        end
      end
`else
      if (s) lat = FULL_LAT;
`endif
    end
  endtask

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    exp_t e;
    int   lat;
    int   guard;
    guard = 0;
    @(negedge clk);
    while (!ready_o && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!ready_o) begin
      check("ready_timeout", W'(ready_o), W'(1'b1));
      return;
    end
    model(a, b, s, e.q, e.r, lat);
    e.due = cyc + lat;
    dividend_i = a;
    divisor_i  = b;
    signed_i   = s;
    start_i    = 1'b1;
    #1;
    check("stall_on_request", W'(stall_o), W'(1'b1));
    sbq.push_back(e);
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (sbq.size() != 0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check("drain_timeout", W'(sbq.size()), '0);
  endtask

  initial begin
    fork
      forever begin
        exp_t e;
        @(negedge clk);
        if (rst_n && done_o) begin
          if (sbq.size() == 0) begin
            check("unexpected_done", W'(done_o), W'(1'b0));
          end else begin
            e = sbq.pop_front();
            check("quotient", quotient_o, e.q);
            check("remainder", remainder_o, e.r);
            check("done_cycle", W'(cyc), W'(e.due));
            check("stall_in_done", W'(stall_o), '0);
            check("ready_in_done", W'(ready_o), '0);
          end
        end
      end
    join_none

    // Reset state and combinational stall in IDLE
    repeat (3) @(negedge clk);
    check("rst_ready", W'(ready_o), W'(1'b1));
    check("rst_done", W'(done_o), '0);
    check("rst_quotient", quotient_o, '0);
    check("rst_remainder", remainder_o, '0);
    check("idle_stall_low", W'(stall_o), '0);
    start_i = 1'b1;
    #1;
    check("idle_stall_follows_start", W'(stall_o), W'(1'b1));
    start_i = 1'b0;
    rst_n = 1'b1;

    // 100 / 7 with stall window: RUN lasts exactly W cycles after the request
    begin
      int n;
      issue(32'd100, 32'd7, 1'b0);
      n = 0;
      while (stall_o && n < 100) begin
        n++;
        @(negedge clk);
      end
      check("stall_run_cycles", W'(n), W'(W));
      check("done_after_stall", W'(done_o), W'(1'b1));
    end
    drain();

    issue(32'd5, 32'd0, 1'b0);
    drain();
    issue(32'hFFFF_FFF9, 32'd2, 1'b1);
    issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    issue(32'hFFFF_FFF9, 32'd2, 1'b0);
    issue(32'h0000_0010, 32'hFFFF_FFFE, 1'b1);
    drain();

    // Start during RUN must be dropped, not queued
    issue(32'd100, 32'd7, 1'b0);
    repeat (9) @(negedge clk);
    check("busy_not_ready", W'(ready_o), '0);
    dividend_i = 32'd1000;
    divisor_i  = 32'd3;
    start_i    = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    drain();
    repeat (3) @(negedge clk);
    check("no_queued_request", W'(sbq.size()), '0);
    issue(32'd1000, 32'd3, 1'b0);
    drain();

    // Reset in the middle of RUN discards the operation
    issue(32'hFFFF_0000, 32'd3, 1'b0);
    repeat (14) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrun_rst_ready", W'(ready_o), W'(1'b1));
    check("midrun_rst_quotient", quotient_o, '0);
    check("midrun_rst_remainder", remainder_o, '0);
    check("midrun_rst_done", W'(done_o), '0);
    sbq.delete();
    rst_n = 1'b1;
    repeat (W + 5) @(negedge clk);
    issue(32'd9, 32'd3, 1'b0);
    drain();

    // Randomized back-to-back and gapped traffic
    for (int i = 0; i < 30; i++) begin
      logic [W-1:0] a;
      logic [W-1:0] b;
      int           mode;
      a    = $urandom;
      mode = $urandom_range(0, 5);
      case (mode)
        0:       b = '0;
        1:       b = W'($urandom_range(1, 15));
        2:       b = '1;
        3:       b = $urandom >> $urandom_range(0, 31);
        default: b = $urandom;
      endcase
      if (mode == 2 && $urandom_range(0, 1) == 1) a = 32'h8000_0000;
      if (b == 0 && mode != 0) b = 32'd1;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      issue(a, b, 1'($urandom_range(0, 1)));
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
